mdio_receptor_c45: RTL

//  PHY-side MDIO target; generalises mdio_receptor with Clause 22 + optional Clause 45 framing,
//  PHY-address filtering, preamble checking, a read path that drives MDIO_IN, and error flagging.

---
 rtl/mdio_pkg.sv | 57 +++++
 rtl/mdio_preamble_det.sv | 44 ++++
 rtl/mdio_receptor_c45.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mdio_pkg
// Purpose : Shared MDIO frame codes, FSM states, bit positions and frame decode.
// Rev     : 1.0
// ============================================================================
package mdio_pkg;

    localparam logic [1:0] ST_CL22   = 2'b01;
    localparam logic [1:0] ST_CL45   = 2'b00;
    localparam logic [1:0] OP22_WR   = 2'b01;
    localparam logic [1:0] OP22_RD   = 2'b10;
    localparam logic [1:0] OP45_ADDR = 2'b00;
    localparam logic [1:0] OP45_WR   = 2'b01;
    localparam logic [1:0] OP45_PRI  = 2'b10;
    localparam logic [1:0] OP45_RD   = 2'b11;
    localparam logic [1:0] TA_WRITE  = 2'b10;

    localparam logic [4:0] ST_END   = 5'd1;
    localparam logic [4:0] OP_END   = 5'd3;
    localparam logic [4:0] PHY_END  = 5'd8;
    localparam logic [4:0] REG_END  = 5'd13;
    localparam logic [4:0] TA_END   = 5'd15;
    localparam logic [4:0] DATA_END = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REG, S_TA, S_DATA
    } state_t;

    typedef enum logic [2:0] {
        F_BAD, F_WR22, F_RD22, F_ADDR45, F_WR45, F_RD45, F_PRI45
    } frame_t;

    function automatic frame_t decode_frame(input logic [1:0] st, input logic [1:0] op,
                                            input logic cl45_en);
        frame_t f;
        f = F_BAD;
        if (st == ST_CL22) begin
            if (op == OP22_WR)      f = F_WR22;
            else if (op == OP22_RD) f = F_RD22;
        end else if (st == ST_CL45 && cl45_en) begin
            case (op)
                OP45_ADDR: f = F_ADDR45;
                OP45_WR:   f = F_WR45;
                OP45_PRI:  f = F_PRI45;
                default:   f = F_RD45;
            endcase
        end
        return f;
    endfunction

    function automatic logic is_read(input frame_t f);
        return (f == F_RD22) || (f == F_RD45) || (f == F_PRI45);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_preamble_det.sv
`default_nettype none
// ============================================================================
// Module  : mdio_preamble_det
// Purpose : Saturating count of idle '1' bits; flags a frame start on '0'.
// Rev     : 1.0
// ============================================================================
module mdio_preamble_det #(
    parameter int PREAMBLE_MIN = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic mdio_bit,
    output logic start
);

    localparam int CW = (PREAMBLE_MIN > 0) ? $clog2(PREAMBLE_MIN + 1) : 1;

    logic [CW-1:0] count;
    logic          min_met;

    // Count saturates at the minimum, so reaching it is an equality test.
    generate
        if (PREAMBLE_MIN == 0) begin : g_no_min
            assign min_met = 1'b1;
        end else begin : g_min
            assign min_met = (count == CW'(PREAMBLE_MIN));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (idle && mdio_bit) begin
            if (!min_met) count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    assign start = idle && !mdio_bit && min_met;

endmodule
`default_nettype wire

// File: rtl/mdio_receptor_c45.sv
`default_nettype none
// ============================================================================
// Module  : mdio_receptor_c45
// Purpose : PHY-side MDIO target, Clause 22/45 framing, one register access per frame.
// Rev     : 1.0
// ============================================================================
module mdio_receptor_c45
    import mdio_pkg::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter bit CL45_EN      = 1'b1,
    parameter bit BCAST_EN     = 1'b1
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic [4:0]  PHY_ADDR,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_EN,
    output logic [15:0] ADDR,
    output logic [4:0]  DEVAD,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        MDIO_DONE,
    output logic        FRAME_ERR
);

    state_t      state;
    frame_t      frame;
    frame_t      frame_dec;
    logic [4:0]  bit_idx;
    logic [14:0] sh;
    logic [15:0] rd_sh;
    logic [4:0]  field;
    logic        hit;
    logic        mdio_bit;
    logic        start;

    assign mdio_bit  = MDIO_OE ? MDIO_OUT : 1'b1;
    assign field     = {sh[3:0], mdio_bit};
    assign frame_dec = decode_frame(sh[2:1], {sh[0], mdio_bit}, CL45_EN);

    mdio_preamble_det #(.PREAMBLE_MIN(PREAMBLE_MIN)) u_pre (
        .clk      (MDC),
        .rst      (RESET),
        .idle     (state == S_IDLE),
        .mdio_bit (mdio_bit),
        .start    (start)
    );

    always_ff @(posedge MDC or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            frame      <= F_BAD;
            bit_idx    <= '0;
            sh         <= '0;
            rd_sh      <= '0;
            hit        <= 1'b0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_EN <= 1'b0;
            ADDR       <= '0;
            DEVAD      <= '0;
            WR_DATA    <= '0;
            WR_STB     <= 1'b0;
            RD_STB     <= 1'b0;
            MDIO_DONE  <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            MDIO_DONE <= 1'b0;
            FRAME_ERR <= 1'b0;
            sh        <= {sh[13:0], mdio_bit};
            bit_idx   <= bit_idx + 5'd1;
            case (state)
                S_IDLE: begin
                    bit_idx <= 5'd1;
                    if (start) state <= S_ST;
                end
                S_ST: if (bit_idx == ST_END) state <= S_OP;
                S_OP: if (bit_idx == OP_END) begin
                    frame <= frame_dec;
                    if (frame_dec == F_BAD) begin
                        FRAME_ERR <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_PHYAD;
                    end
                end
                S_PHYAD: if (bit_idx == PHY_END) begin
                    // Broadcast never answers a read: two PHYs would fight over MDIO.
                    hit   <= (field == PHY_ADDR) || (BCAST_EN && (field == 5'd0) && !is_read(frame));
                    state <= S_REG;
                end
                S_REG: if (bit_idx == REG_END) begin
                    state <= S_TA;
                    if (hit) begin
                        if (frame == F_WR22 || frame == F_RD22) begin
                            ADDR  <= {11'b0, field};
                            DEVAD <= '0;
                        end else begin
                            DEVAD <= field;
                        end
                        RD_STB <= is_read(frame);
                    end
                end
                S_TA: begin
                    if (hit && is_read(frame)) begin
                        if (bit_idx == TA_END) begin
                            MDIO_IN <= rd_sh[15];
                            rd_sh   <= {rd_sh[14:0], 1'b0};
                        end else begin
                            MDIO_IN_EN <= 1'b1;
                            MDIO_IN    <= 1'b0;
                            rd_sh      <= RD_DATA;
                        end
                    end
                    if (bit_idx == TA_END) begin
                        if (hit && !is_read(frame) && ({sh[0], mdio_bit} != TA_WRITE)) begin
                            FRAME_ERR <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_idx == DATA_END) begin
                        state <= S_IDLE;
                        if (hit) begin
                            MDIO_DONE  <= 1'b1;
                            MDIO_IN_EN <= 1'b0;
                            MDIO_IN    <= 1'b0;
                            case (frame)
                                F_WR22, F_WR45: begin
                                    WR_STB  <= 1'b1;
                                    WR_DATA <= {sh[14:0], mdio_bit};
                                end
                                F_ADDR45: ADDR <= {sh[14:0], mdio_bit};
                                F_PRI45:  ADDR <= ADDR + 16'd1;
                                default: ;
                            endcase
                        end
                    end else if (hit && is_read(frame)) begin
                        MDIO_IN <= rd_sh[15];
                        rd_sh   <= {rd_sh[14:0], 1'b0};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
